// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single main-memory port between I-cache and D-cache miss/refill
//   requests. One word transaction is in flight at a time. When both sides ask
//   together, the side that was not served last wins (round-robin). Each grant
//   holds mem_en for a fixed MEM_LATENCY cycles, and the read data is sampled in
//   the last of those cycles. A global freeze stalls every pipeline register
//   while a transaction is pending and releases for exactly one cycle (DONE).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   i_req      in   I-cache miss request (level, held until i_done)
//   i_addr     in   I-side word address
//   d_req      in   D-cache miss/store request (level, held until d_done)
//   d_we       in   D-side write (store write-through)
//   d_addr     in   D-side word address
//   d_wdata    in   D-side store data
//   mem_en     out  memory access active
//   mem_we     out  memory write strobe
//   mem_addr   out  latched address of the granted requester
//   mem_wdata  out  latched store data
//   mem_rdata  in   memory read data, valid in the last mem_en cycle
//   rdata      out  captured read data returned to the granted requester
//   i_done     out  one-cycle completion pulse, I side
//   d_done     out  one-cycle completion pulse, D side
//   freeze     out  stall to all pipeline registers
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              i_done,
  output logic              d_done,
  output logic              freeze
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  // 1 = D side was granted last, 0 = I side. It also names the side that
  // receives the done pulse, since DONE always follows the latest grant.
  logic              last_grant_reg, last_grant_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              grant_d;

  // D wins when it is alone, or when both ask and I was served last.
  assign grant_d = d_req & (~i_req | ~last_grant_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_grant_reg <= last_grant_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      rdata_reg      <= rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_grant_next = last_grant_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    rdata_next      = rdata_reg;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    i_done          = 1'b0;
    d_done          = 1'b0;
    freeze          = 1'b0;

    case (state_reg)
      IDLE: begin
        // Stall as soon as a request appears so the requesting stage holds.
        freeze = i_req | d_req;
        if (grant_d) begin
          state_next      = GRANT_D;
          addr_next       = d_addr;
          we_next         = d_we;
          wdata_next      = d_wdata;
          cnt_next        = CNT_LOAD;
          last_grant_next = 1'b1;
        end else if (i_req) begin
          state_next      = GRANT_I;
          addr_next       = i_addr;
          we_next         = 1'b0;
          cnt_next        = CNT_LOAD;
          last_grant_next = 1'b0;
        end
      end

      GRANT_I, GRANT_D: begin
        mem_en = 1'b1;
        mem_we = we_reg;
        freeze = 1'b1;
        if (cnt_reg == '0) begin
          // Last access cycle: memory data is valid now. Stores leave rdata alone.
          if (!we_reg) begin
            rdata_next = mem_rdata;
          end
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      DONE: begin
        // freeze stays low here: the pipeline advances on exactly this cycle.
        i_done     = ~last_grant_reg;
        d_done     = last_grant_reg;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign rdata     = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int L  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance, MEM_LATENCY = 4
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic          mem_en, mem_we, i_done, d_done, freeze;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rdata;

  // Second instance, MEM_LATENCY = 1
  logic          l1_i_req = 1'b0, l1_d_req = 1'b0, l1_d_we = 1'b0;
  logic [AW-1:0] l1_i_addr = '0, l1_d_addr = '0;
  logic [DW-1:0] l1_d_wdata = '0, l1_mem_rdata = '0;
  logic          l1_mem_en, l1_mem_we, l1_i_done, l1_d_done, l1_freeze;
  logic [AW-1:0] l1_mem_addr;
  logic [DW-1:0] l1_mem_wdata, l1_rdata;

  int n_cmp = 0;
  int n_mis = 0;

  mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rdata(rdata),
    .i_done(i_done), .d_done(d_done), .freeze(freeze)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(AW), .DATA_W(DW)) dut_l1 (
    .clk(clk), .rst(rst),
    .i_req(l1_i_req), .i_addr(l1_i_addr),
    .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .rdata(l1_rdata),
    .i_done(l1_i_done), .d_done(l1_d_done), .freeze(l1_freeze)
  );

  // Stimulus only: pulse reset for one cycle, leave all requests low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    l1_i_req = 1'b0; l1_d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b0) begin n_mis++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
    n_cmp++; if (mem_we !== 1'b0) begin n_mis++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== '0) begin n_mis++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== '0) begin n_mis++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (rdata !== '0) begin n_mis++; $display("FAIL rst_rdata got %h want 0", rdata); end
    n_cmp++; if ({i_done, d_done} !== 2'b00) begin n_mis++; $display("FAIL rst_done got %b want 00", {i_done, d_done}); end
    n_cmp++; if (freeze !== 1'b0) begin n_mis++; $display("FAIL rst_freeze got %b want 0", freeze); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mem_en, freeze} !== 2'b00) begin n_mis++; $display("FAIL rst_idle got %b want 00", {mem_en, freeze}); end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    #1;
    n_cmp++; if (freeze !== 1'b1) begin n_mis++; $display("FAIL t1_freeze c=0 got %b want 1", freeze); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_en !== (c <= 4)) begin n_mis++; $display("FAIL t1_mem_en c=%0d got %b want %b", c, mem_en, (c <= 4)); end
      n_cmp++; if (freeze !== (c <= 4)) begin n_mis++; $display("FAIL t1_freeze c=%0d got %b want %b", c, freeze, (c <= 4)); end
      n_cmp++; if (d_done !== (c == 5)) begin n_mis++; $display("FAIL t1_d_done c=%0d got %b want %b", c, d_done, (c == 5)); end
      n_cmp++; if (i_done !== 1'b0) begin n_mis++; $display("FAIL t1_i_done c=%0d got %b want 0", c, i_done); end
      if (c <= 4) begin
        n_cmp++; if (mem_addr !== 32'h100) begin n_mis++; $display("FAIL t1_mem_addr c=%0d got %h want 100", c, mem_addr); end
      end
      mem_rdata = (c == 4) ? 32'hDEADBEEF : $urandom;
    end
    n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_mis++; $display("FAIL t1_rdata got %h want deadbeef", rdata); end
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mem_en, d_done, freeze} !== 3'b000) begin n_mis++; $display("FAIL t1_after got %b want 000", {mem_en, d_done, freeze}); end
    $display("test_single_read done");
  endtask

  // Both requests rise together after reset and stay high for four transactions.
  task automatic test_both_order();
    int ph;
    do_reset();
    @(negedge clk);
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h200; d_addr = 32'h300;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      ph = c % 6;
      n_cmp++; if (mem_en !== (ph >= 1 && ph <= 4)) begin n_mis++; $display("FAIL t2_mem_en c=%0d got %b", c, mem_en); end
      n_cmp++; if (d_done !== (c == 5 || c == 17)) begin n_mis++; $display("FAIL t2_d_done c=%0d got %b", c, d_done); end
      n_cmp++; if (i_done !== (c == 11 || c == 23)) begin n_mis++; $display("FAIL t2_i_done c=%0d got %b", c, i_done); end
      if (ph >= 1 && ph <= 4) begin
        n_cmp++;
        if (mem_addr !== (((c / 6) % 2 == 0) ? 32'h300 : 32'h200)) begin
          n_mis++; $display("FAIL t2_grant_order c=%0d mem_addr got %h", c, mem_addr);
        end
      end
      mem_rdata = $urandom;
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    $display("test_both_order done");
  endtask

  task automatic test_write();
    // Preload rdata through an ordinary read.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; mem_rdata = 32'hA5A5A5A5;
    repeat (5) @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (rdata !== 32'hA5A5A5A5) begin n_mis++; $display("FAIL t4_preload got %h want a5a5a5a5", rdata); end
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_we !== (c <= 4)) begin n_mis++; $display("FAIL t4_mem_we c=%0d got %b", c, mem_we); end
      n_cmp++; if (mem_en !== (c <= 4)) begin n_mis++; $display("FAIL t4_mem_en c=%0d got %b", c, mem_en); end
      n_cmp++; if (d_done !== (c == 5)) begin n_mis++; $display("FAIL t4_d_done c=%0d got %b", c, d_done); end
      if (c <= 4) begin
        n_cmp++; if (mem_wdata !== 32'h12345678) begin n_mis++; $display("FAIL t4_mem_wdata c=%0d got %h want 12345678", c, mem_wdata); end
      end
      mem_rdata = $urandom;
    end
    n_cmp++; if (rdata !== 32'hA5A5A5A5) begin n_mis++; $display("FAIL t4_rdata got %h want a5a5a5a5", rdata); end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    $display("test_write done");
  endtask

  task automatic test_reset_midgrant();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h80;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_en !== 1'b1) begin n_mis++; $display("FAIL t5_pre_mem_en c=%0d got %b want 1", c, mem_en); end
    end
    rst = 1'b1;
    #1;
    n_cmp++; if ({mem_en, mem_we} !== 2'b00) begin n_mis++; $display("FAIL t5_rst_en_we got %b want 00", {mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== '0) begin n_mis++; $display("FAIL t5_rst_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== '0) begin n_mis++; $display("FAIL t5_rst_mem_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (rdata !== '0) begin n_mis++; $display("FAIL t5_rst_rdata got %h want 0", rdata); end
    n_cmp++; if ({i_done, d_done} !== 2'b00) begin n_mis++; $display("FAIL t5_rst_done got %b want 00", {i_done, d_done}); end
    @(negedge clk);
    n_cmp++; if ({mem_en, i_done} !== 2'b00) begin n_mis++; $display("FAIL t5_hold got %b want 00", {mem_en, i_done}); end
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_en !== (c <= 4)) begin n_mis++; $display("FAIL t5_mem_en c=%0d got %b", c, mem_en); end
      n_cmp++; if (i_done !== (c == 5)) begin n_mis++; $display("FAIL t5_i_done c=%0d got %b", c, i_done); end
      if (c <= 4) begin
        n_cmp++; if (mem_addr !== 32'h80) begin n_mis++; $display("FAIL t5_mem_addr c=%0d got %h want 80", c, mem_addr); end
      end
    end
    i_req = 1'b0;
    @(negedge clk);
    $display("test_reset_midgrant done");
  endtask

  task automatic test_latency1();
    @(negedge clk);
    l1_i_req = 1'b1; l1_i_addr = 32'h40;
    #1;
    n_cmp++; if (l1_freeze !== 1'b1) begin n_mis++; $display("FAIL t6_freeze c=0 got %b want 1", l1_freeze); end
    @(negedge clk);
    n_cmp++; if (l1_mem_en !== 1'b1) begin n_mis++; $display("FAIL t6_mem_en c=1 got %b want 1", l1_mem_en); end
    n_cmp++; if (l1_mem_addr !== 32'h40) begin n_mis++; $display("FAIL t6_mem_addr got %h want 40", l1_mem_addr); end
    n_cmp++; if (l1_i_done !== 1'b0) begin n_mis++; $display("FAIL t6_i_done c=1 got %b want 0", l1_i_done); end
    l1_mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    n_cmp++; if (l1_mem_en !== 1'b0) begin n_mis++; $display("FAIL t6_mem_en c=2 got %b want 0", l1_mem_en); end
    n_cmp++; if (l1_i_done !== 1'b1) begin n_mis++; $display("FAIL t6_i_done c=2 got %b want 1", l1_i_done); end
    n_cmp++; if (l1_freeze !== 1'b0) begin n_mis++; $display("FAIL t6_freeze c=2 got %b want 0", l1_freeze); end
    n_cmp++; if (l1_rdata !== 32'hCAFEF00D) begin n_mis++; $display("FAIL t6_rdata got %h want cafef00d", l1_rdata); end
    l1_i_req = 1'b0; l1_mem_rdata = $urandom;
    @(negedge clk);
    n_cmp++; if ({l1_mem_en, l1_i_done, l1_freeze} !== 3'b000) begin n_mis++; $display("FAIL t6_after got %b want 000", {l1_mem_en, l1_i_done, l1_freeze}); end
    $display("test_latency1 done");
  endtask

  // Random traffic checked against a transaction-level model: pending flags per
  // side, a last-served side, and the expected address/data of each transaction.
  task automatic test_random(input int n_txn);
    bit pi, pd, last, win, ewe;
    logic [31:0] eaddr, ewdata, erdata, rd_m;
    do_reset();
    pi = 1'b0; pd = 1'b0; last = 1'b0; rd_m = '0; erdata = '0;
    for (int t = 0; t < n_txn; t++) begin
      @(negedge clk);
      if (!pi && !pd) begin
        n_cmp++; if (freeze !== 1'b0) begin n_mis++; $display("FAIL rnd_idle_freeze t=%0d got %b want 0", t, freeze); end
        pi = 1'($urandom_range(0, 1));
        pd = 1'($urandom_range(0, 1));
        if (!pi && !pd) pi = 1'b1;
        if (pi) begin i_req = 1'b1; i_addr = $urandom; end
        if (pd) begin d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom; end
      end
      #1;
      n_cmp++; if (freeze !== 1'b1) begin n_mis++; $display("FAIL rnd_req_freeze t=%0d got %b want 1", t, freeze); end
      win    = (pd && !pi) ? 1'b1 : (pi && !pd) ? 1'b0 : ~last;
      last   = win;
      eaddr  = win ? d_addr : i_addr;
      ewe    = win ? d_we : 1'b0;
      ewdata = d_wdata;
      for (int c = 1; c <= L; c++) begin
        @(negedge clk);
        n_cmp++; if (mem_en !== 1'b1) begin n_mis++; $display("FAIL rnd_mem_en t=%0d c=%0d got %b want 1", t, c, mem_en); end
        n_cmp++; if (mem_we !== ewe) begin n_mis++; $display("FAIL rnd_mem_we t=%0d c=%0d got %b want %b", t, c, mem_we, ewe); end
        n_cmp++; if (mem_addr !== eaddr) begin n_mis++; $display("FAIL rnd_mem_addr t=%0d c=%0d got %h want %h", t, c, mem_addr, eaddr); end
        n_cmp++; if ({i_done, d_done, freeze} !== 3'b001) begin n_mis++; $display("FAIL rnd_grant_flags t=%0d c=%0d got %b want 001", t, c, {i_done, d_done, freeze}); end
        if (ewe) begin
          n_cmp++; if (mem_wdata !== ewdata) begin n_mis++; $display("FAIL rnd_mem_wdata t=%0d got %h want %h", t, mem_wdata, ewdata); end
        end
        mem_rdata = $urandom;
        if (c == L) erdata = mem_rdata;
        // A request from the other side arriving mid-grant has to wait its turn.
        if (c == 2 && $urandom_range(0, 2) == 0) begin
          if (win && !pi) begin pi = 1'b1; i_req = 1'b1; i_addr = $urandom; end
          else if (!win && !pd) begin pd = 1'b1; d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom; end
        end
      end
      @(negedge clk);
      if (!ewe) rd_m = erdata;
      n_cmp++; if ({i_done, d_done} !== {~win, win}) begin n_mis++; $display("FAIL rnd_done t=%0d got %b want %b", t, {i_done, d_done}, {~win, win}); end
      n_cmp++; if ({mem_en, freeze} !== 2'b00) begin n_mis++; $display("FAIL rnd_done_flags t=%0d got %b want 00", t, {mem_en, freeze}); end
      n_cmp++; if (rdata !== rd_m) begin n_mis++; $display("FAIL rnd_rdata t=%0d got %h want %h", t, rdata, rd_m); end
      if ($urandom_range(0, 3) == 0) begin
        // Winner keeps its request high: a new back-to-back transaction.
        if (win) begin d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom; end
        else i_addr = $urandom;
      end else if (win) begin
        pd = 1'b0; d_req = 1'b0;
      end else begin
        pi = 1'b0; i_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    $display("test_random done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_both_order();
    test_write();
    test_reset_midgrant();
    test_latency1();
    test_random(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
